// File: rtl/uart_nonce_pkg.sv
// Shared definitions for the nonce result-return path: frame layout, FSM states, and byte helpers.
package uart_nonce_pkg;

  localparam int unsigned FRAME_LEN = 6;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hAA;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StHold,
    StWait
  } state_e;

  function automatic logic [7:0] nonce_csum(input logic [31:0] nonce);
    return nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0];
  endfunction

  // Byte idx of a frame: sync, four nonce bytes MSB first, then checksum.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [31:0] frame,
                                            input logic [7:0]  csum,
                                            input logic [7:0]  sync);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = frame[31:24];
      3'd2:    b = frame[23:16];
      3'd3:    b = frame[15:8];
      3'd4:    b = frame[7:0];
      default: b = csum;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_nonce_reporter_if.sv
// Nonce result bus plus byte-level UART transmitter handshake.
interface uart_nonce_reporter_if;

  logic        nonce_valid;
  logic [31:0] nonce_data;
  logic        nonce_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  modport slave (
    input  nonce_valid,
    input  nonce_data,
    input  tx_busy,
    output nonce_ready,
    output tx_start,
    output tx_data
  );

  modport master (
    output nonce_valid,
    output nonce_data,
    output tx_busy,
    input  nonce_ready,
    input  tx_start,
    input  tx_data
  );

endinterface

// File: rtl/nonce_fifo.sv
// 32-bit synchronous FIFO with power-of-2 depth; pointers wrap naturally modulo DEPTH.
module nonce_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("nonce_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [31:0]     mem_q [DEPTH];
  logic            do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_nonce_reporter.sv
// Buffers found nonces and serializes each as a 6-byte frame (sync, 4 nonce bytes, XOR checksum)
// into the UART transmitter via its start/busy handshake.
module uart_nonce_reporter
  import uart_nonce_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  uart_nonce_reporter_if.slave         bus,
  output logic [7:0]                   drop_cnt,
  output logic                         active
);

  localparam logic [2:0] LastIdx = 3'(FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic [7:0]  csum_q, csum_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  drop_q, drop_d;
  logic        tx_start;

  logic        fifo_push, fifo_pop;
  logic [31:0] fifo_dout;
  logic        fifo_full, fifo_empty;

  assign fifo_push       = bus.nonce_valid && !fifo_full;
  assign bus.nonce_ready = !fifo_full;
  assign bus.tx_start    = tx_start;
  assign bus.tx_data     = tx_data_q;
  assign drop_cnt        = drop_q;
  assign active          = (state_q != StIdle);

  nonce_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (bus.nonce_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // tx_data is loaded on entry to SEND so it is already valid during the start pulse.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    tx_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          frame_d   = fifo_dout;
          csum_d    = nonce_csum(fifo_dout);
          idx_d     = 3'd0;
          tx_data_d = SYNC_BYTE;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (!bus.tx_busy) begin
          tx_start = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        state_d = StWait;
      end
      StWait: begin
        if (!bus.tx_busy) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = frame_byte(idx_q + 3'd1, frame_q, csum_q, SYNC_BYTE);
            state_d   = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (bus.nonce_valid && fifo_full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      csum_q    <= '0;
      idx_q     <= '0;
      tx_data_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_uart_nonce_reporter.sv
// Self-checking bench: behavioural UART busy model, byte scoreboard fed from accepted nonces.
module tb_uart_nonce_reporter;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  SYNC  = 8'hAA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] drop_cnt;
  logic       active;

  uart_nonce_reporter_if bus ();

  uart_nonce_reporter #(
    .DEPTH    (DEPTH),
    .SYNC_BYTE(SYNC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .drop_cnt(drop_cnt),
    .active  (active)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference frames straight from the frame definition.
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] t1_bytes [6]  = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
  logic [7:0] t2_bytes [12] = '{8'hAA, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22,
                                8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] t5_bytes [6]  = '{8'hAA, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};

  task automatic add_frame(input logic [31:0] n);
    logic [7:0] c;
    c = 8'h00;
    exp_q.push_back(SYNC);
    for (int k = 3; k >= 0; k--) begin
      exp_q.push_back(8'((n >> (8 * k)) & 32'hFF));
      c = c ^ 8'((n >> (8 * k)) & 32'hFF);
    end
    exp_q.push_back(c);
  endtask

  int   cyc = 0;
  int   last_push_cyc = 0;
  int   start_cyc_q[$];
  int   n_starts = 0;
  int   n_acc = 0;
  int   drop_model = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_start = 1'b0;
      drop_model = 0;
    end else begin
      if (bus.nonce_valid && bus.nonce_ready) begin
        add_frame(bus.nonce_data);
        last_push_cyc = cyc;
        n_acc++;
      end
      if (bus.nonce_valid && !bus.nonce_ready) drop_model = (drop_model < 255) ? drop_model + 1 : 255;
      if (bus.tx_start) begin
        n_starts++;
        start_cyc_q.push_back(cyc);
        rx_q.push_back(bus.tx_data);
        check_eq("start_gap", prev_start, 0);
        if (exp_q.size() == 0) check_eq("extra_byte", exp_q.size(), 1);
        else check_eq("tx_byte", bus.tx_data, exp_q.pop_front());
      end
      prev_start = bus.tx_start;
    end
  end

  // Transmitter: busy rises the cycle after HOLD and stays high for a random length.
  int   busy_lo = 0;
  int   busy_hi = 0;
  logic force_busy = 1'b0;

  initial begin : tx_model
    logic st;
    bit   arm;
    int   cnt;
    bus.tx_busy = 1'b0;
    arm = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      st = bus.tx_start;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        arm = 0;
        cnt = 0;
      end else begin
        if (arm) begin
          cnt = $urandom_range(busy_hi, busy_lo);
          arm = 0;
        end
        if (st) arm = 1;
      end
      bus.tx_busy = force_busy || (cnt > 0);
      if (cnt > 0) cnt--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    step();
    bus.nonce_valid = v;
    bus.nonce_data  = d;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    bit ok;
    k  = 0;
    ok = 0;
    while (k < budget && !ok) begin
      step();
      k++;
      if (exp_q.size() == 0 && !active && !bus.tx_busy) ok = 1;
    end
    check_eq(tag, ok, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, exp_drop, k, acc0;
    bit found;
    bus.nonce_valid = 1'b0;
    bus.nonce_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_tx_start", bus.tx_start, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_drop", drop_cnt, 0);
    check_eq("rst_active", active, 0);
    check_eq("rst_ready", bus.nonce_ready, 1);
    step();
    rst_n = 1'b1;

    // Single nonce, fixed 10-cycle busy
    busy_lo = 10; busy_hi = 10;
    rx_q.delete(); start_cyc_q.delete();
    base = n_starts;
    drive(1'b1, 32'h12345678);
    drive(1'b0, 32'h0);
    wait_idle(400, "t1_drain");
    check_eq("t1_nstarts", n_starts - base, 6);
    if (start_cyc_q.size() > 0) check_eq("t1_latency", start_cyc_q[0] - last_push_cyc, 2);
    check_eq("t1_nbytes", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) check_eq("t1_byte", rx_q[i], t1_bytes[i]);

    // Two nonces back to back
    busy_lo = 0; busy_hi = 4;
    rx_q.delete();
    drive(1'b1, 32'hDEADBEEF);
    drive(1'b1, 32'h00000000);
    drive(1'b0, 32'h0);
    wait_idle(800, "t2_drain");
    check_eq("t2_nbytes", rx_q.size(), 12);
    for (int i = 0; i < 12 && i < rx_q.size(); i++) check_eq("t2_byte", rx_q[i], t2_bytes[i]);

    // Fill while the transmitter is held busy, then saturate the drop counter
    busy_lo = 0; busy_hi = 6;
    force_busy = 1'b1;
    step(); step();
    base = n_starts;
    for (int i = 0; i < 6; i++) drive(1'b1, $urandom);
    drive(1'b0, 32'h0);
    exp_drop = 6 - (DEPTH + 1);
    check_eq("t4_ready_low", bus.nonce_ready, 0);
    check_eq("t4_drop", drop_cnt, exp_drop);
    check_eq("t4_active", active, 1);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, $urandom);
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    drive(1'b0, 32'h0);
    check_eq("t4_drop_sat", drop_cnt, exp_drop);
    check_eq("t4_drop_model", drop_cnt, drop_model);
    check_eq("t4_no_start", n_starts - base, 0);
    force_busy = 1'b0;
    wait_idle(5000, "t4_drain");
    check_eq("t4_nstarts", n_starts - base, 6 * (DEPTH + 1));

    // Reset in the middle of byte 3
    busy_lo = 8; busy_hi = 8;
    base = n_starts;
    drive(1'b1, 32'hCAFEF00D);
    drive(1'b1, 32'h13572468);
    drive(1'b0, 32'h0);
    k = 0;
    while (k < 500 && (n_starts - base) < 3) begin
      step();
      k++;
    end
    check_eq("t5_reach_byte3", (n_starts - base) >= 3, 1);
    step(); step();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("t5_tx_start", bus.tx_start, 0);
    check_eq("t5_active", active, 0);
    check_eq("t5_ready", bus.nonce_ready, 1);
    check_eq("t5_drop", drop_cnt, 0);
    check_eq("t5_tx_data", bus.tx_data, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    rx_q.delete();
    drive(1'b1, 32'h0000FFFF);
    drive(1'b0, 32'h0);
    wait_idle(600, "t5_drain");
    check_eq("t5_nbytes", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) check_eq("t5_byte", rx_q[i], t5_bytes[i]);

    // Push and pop on the same edge with one entry queued, across pointer wrap
    busy_lo = 0; busy_hi = 3;
    base = n_starts;
    force_busy = 1'b1;
    drive(1'b1, $urandom);
    drive(1'b0, 32'h0);
    step(); step(); step();
    drive(1'b1, $urandom);
    drive(1'b0, 32'h0);
    force_busy = 1'b0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      found = 0;
      k = 0;
      while (!found && k < 2000) begin
        if (!active) found = 1;
        else begin
          step();
          k++;
        end
      end
      check_eq("t6_reach_idle", found, 1);
      if (!found) break;
      check_eq("t6_ready", bus.nonce_ready, 1);
      bus.nonce_valid = 1'b1;
      bus.nonce_data  = $urandom;
      step();
      bus.nonce_valid = 1'b0;
      check_eq("t6_popped", active, 1);
      check_eq("t6_ready_after", bus.nonce_ready, 1);
    end
    wait_idle(5000, "t6_drain");
    check_eq("t6_nstarts", n_starts - base, 6 * (2 + 3 * DEPTH));

    // Random stream with random transmitter busy times
    busy_lo = 0; busy_hi = 6;
    base = n_starts;
    acc0 = n_acc;
    for (int i = 0; i < 80; i++) drive($urandom_range(0, 2) == 0, $urandom);
    drive(1'b0, 32'h0);
    wait_idle(8000, "t3_drain");
    check_eq("t3_nstarts", n_starts - base, 6 * (n_acc - acc0));
    check_eq("t3_drop_model", drop_cnt, drop_model);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
